// File: rtl/dice_display.sv
// Dice face display: animates a rolling face while the button is held and latches
// the upstream throw on release. Optional capture counter enabled by DICE_STATS_EN.
module dice_display #(
  parameter int unsigned SPIN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] throw,
  output logic [6:0] dots,
  output logic       valid,
  output logic       err,
  output logic [7:0] rolls
);

  typedef enum logic [1:0] {IDLE, ROLLING, SHOW, ERR} state_t;

  localparam logic [7:0] SPIN_LAST  = 8'(SPIN_DIV - 1);
  localparam logic [6:0] DOTS_BLANK = 7'b0000000;
  localparam logic [6:0] DOTS_ERROR = 7'b1111111;

  state_t     r_state, w_state;
  logic       r_button_q;
  logic [2:0] r_face, w_face;
  logic [7:0] r_spin, w_spin;
  logic [6:0] r_dots, w_dots;
  logic       r_valid, w_valid;
  logic       r_err, w_err;
  logic       w_capture;
  logic       w_throw_ok;

  function automatic logic [6:0] f_encode(input logic [2:0] face);
    case (face)
      3'd1:    f_encode = 7'b0000001;
      3'd2:    f_encode = 7'b1000010;
      3'd3:    f_encode = 7'b1000011;
      3'd4:    f_encode = 7'b1100110;
      3'd5:    f_encode = 7'b1100111;
      3'd6:    f_encode = 7'b1111110;
      default: f_encode = DOTS_BLANK;
    endcase
  endfunction

  assign w_capture  = !button && r_button_q;
  assign w_throw_ok = (throw != 3'd0) && (throw != 3'd7);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state = r_state;
    w_face  = r_face;
    w_spin  = r_spin;
    w_dots  = r_dots;
    w_valid = r_valid;
    w_err   = r_err;
    case (r_state)
      IDLE: begin
        w_dots  = DOTS_BLANK;
        w_valid = 1'b0;
        w_err   = 1'b0;
      end
      ROLLING: begin
        w_valid = 1'b0;
        w_err   = 1'b0;
        if (w_capture) begin
          if (w_throw_ok) begin
            w_state = SHOW;
            w_face  = throw;
            w_dots  = f_encode(throw);
            w_valid = 1'b1;
          end else begin
            w_state = ERR;
            w_dots  = DOTS_ERROR;
            w_err   = 1'b1;
          end
        end else begin
          if (r_spin == SPIN_LAST) begin
            w_spin = 8'd0;
            w_face = (r_face == 3'd6) ? 3'd1 : r_face + 3'd1;
          end else begin
            w_spin = r_spin + 8'd1;
          end
          w_dots = f_encode(w_face);
        end
      end
      default: ;  // SHOW and ERR hold until the button goes high again
    endcase
    // A new roll restarts the animation from face 1 regardless of where it came from.
    if (r_state != ROLLING && button) begin
      w_state = ROLLING;
      w_face  = 3'd1;
      w_spin  = 8'd0;
      w_dots  = f_encode(3'd1);
      w_valid = 1'b0;
      w_err   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_button_q <= 1'b0;
      r_face     <= 3'd0;
      r_spin     <= 8'd0;
      r_dots     <= DOTS_BLANK;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_button_q <= button;
      r_face     <= w_face;
      r_spin     <= w_spin;
      r_dots     <= w_dots;
      r_valid    <= w_valid;
      r_err      <= w_err;
    end
  end

  assign dots  = r_dots;
  assign valid = r_valid;
  assign err   = r_err;

`ifdef DICE_STATS_EN
  logic [7:0] r_rolls;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rolls <= 8'd0;
    end else if (w_capture && r_rolls != 8'hFF) begin
      r_rolls <= r_rolls + 8'd1;
    end
  end

  assign rolls = r_rolls;
`else
  assign rolls = 8'd0;
`endif

endmodule

// File: tb/tb_dice_display.sv
// Directed self-checking bench for dice_display with SPIN_DIV = 4; expected rolls
// follow DICE_STATS_EN so the same bench covers both builds.
module tb_dice_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] throw;
  logic [6:0] dots;
  logic       valid;
  logic       err;
  logic [7:0] rolls;

  int checks   = 0;
  int failures = 0;
  int exp_rolls = 0;

  dice_display #(.SPIN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .throw (throw),
    .dots  (dots),
    .valid (valid),
    .err   (err),
    .rolls (rolls)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] face_dots(input int face);
    case (face)
      1:       return 7'b0000001;
      2:       return 7'b1000010;
      3:       return 7'b1000011;
      4:       return 7'b1100110;
      5:       return 7'b1100111;
      6:       return 7'b1111110;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_capture();
`ifdef DICE_STATS_EN
    if (exp_rolls < 255) exp_rolls++;
`endif
  endtask

  initial begin
    rst    = 1'b0;
    button = 1'b1;
    throw  = 3'd0;

    // Reset held two cycles with the button high.
    tick();
    tick();
    check("rst_dots",  8'(dots),  8'h00);
    check("rst_valid", 8'(valid), 8'h00);
    check("rst_err",   8'(err),   8'h00);
    check("rst_rolls", rolls,     8'h00);

    // Release with button held: animation 1,2,3,4 at edges 1,5,9,13; throw must not matter.
    rst = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      throw = 3'($urandom_range(0, 7));
      tick();
      check($sformatf("spin_dots_%0d", n), 8'(dots), 8'(face_dots((n - 1) / 4 + 1)));
      check($sformatf("spin_valid_%0d", n), 8'({valid, err}), 8'h0);
    end

    // Legal capture of 5, then a throw change after capture is ignored.
    throw  = 3'd5;
    button = 1'b0;
    tick();
    count_capture();
    check("cap5_dots",  8'(dots),  8'b1100111);
    check("cap5_valid", 8'(valid), 8'h01);
    check("cap5_err",   8'(err),   8'h00);
    check("cap5_rolls", rolls,     8'(exp_rolls));
    throw = 3'd2;
    tick();
    tick();
    check("hold5_dots",  8'(dots),  8'b1100111);
    check("hold5_valid", 8'(valid), 8'h01);

    // Illegal capture of 7, then a new roll clears the error.
    button = 1'b1;
    tick();
    check("reroll_dots",  8'(dots),  8'b0000001);
    check("reroll_valid", 8'(valid), 8'h00);
    tick();
    throw  = 3'd7;
    button = 1'b0;
    tick();
    count_capture();
    check("cap7_dots",  8'(dots),  8'b1111111);
    check("cap7_err",   8'(err),   8'h01);
    check("cap7_valid", 8'(valid), 8'h00);
    check("cap7_rolls", rolls,     8'(exp_rolls));
    tick();
    check("hold7_err", 8'(err), 8'h01);
    button = 1'b1;
    tick();
    check("clr7_err",  8'(err),  8'h00);
    check("clr7_dots", 8'(dots), 8'b0000001);

    // Illegal capture of 0 is flagged the same way.
    throw  = 3'd0;
    button = 1'b0;
    tick();
    count_capture();
    check("cap0_dots", 8'(dots), 8'b1111111);
    check("cap0_err",  8'(err),  8'h01);

    // Reset on the same edge as a capture of 3 wins.
    button = 1'b1;
    tick();
    tick();
    throw  = 3'd3;
    button = 1'b0;
    rst    = 1'b0;
    tick();
    exp_rolls = 0;
    check("rstcap_dots",  8'(dots),  8'h00);
    check("rstcap_valid", 8'(valid), 8'h00);
    check("rstcap_rolls", rolls,     8'h00);
    rst = 1'b1;
    tick();
    check("idle_dots", 8'(dots), 8'h00);
    button = 1'b1;
    tick();
    check("idle_roll_dots", 8'(dots), 8'b0000001);

    // Reset mid-show discards the face; held button resumes rolling on release.
    button = 1'b0;
    throw  = 3'd6;
    tick();
    count_capture();
    check("cap6_dots", 8'(dots), 8'b1111110);
    button = 1'b1;
    rst    = 1'b0;
    tick();
    exp_rolls = 0;
    check("rstshow_dots",  8'(dots),  8'h00);
    check("rstshow_valid", 8'(valid), 8'h00);
    rst = 1'b1;
    tick();
    check("rstshow_roll_dots", 8'(dots), 8'b0000001);

    // 260 captures: counter saturates at 255 when enabled, stays 0 otherwise.
    for (int i = 0; i < 260; i++) begin
      button = 1'b1;
      tick();
      throw  = 3'(i % 6 + 1);
      button = 1'b0;
      tick();
      count_capture();
    end
    check("sat_dots",  8'(dots),  8'(face_dots(259 % 6 + 1)));
    check("sat_valid", 8'(valid), 8'h01);
`ifdef DICE_STATS_EN
    check("sat_rolls", rolls, 8'd255);
`else
    check("sat_rolls", rolls, 8'd0);
`endif
    check("sat_rolls_model", rolls, 8'(exp_rolls));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
